// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package rvga_mem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } rvga_arb_state_e;

    // Request payload held on the memory side for the whole transaction.
    typedef struct packed {
        rvga_word addr;
        rvga_word data;
    } rvga_mem_req_t;

endpackage

// File: rtl/rvga_mem_arbiter_if.sv
// Bundle of the fetch, data and unified-memory ports around the arbiter.
interface rvga_mem_arbiter_if;
    import rvga_mem_arbiter_pkg::*;

    logic     imem_r_v_i;
    rvga_word imem_addr_i;
    rvga_word imem_data_o;
    logic     imem_resp_v_o;

    logic     dmem_r_v_i;
    logic     dmem_w_v_i;
    rvga_word dmem_addr_i;
    rvga_word dmem_data_i;
    rvga_word dmem_data_o;
    logic     dmem_resp_v_o;

    logic     mem_r_v_o;
    logic     mem_w_v_o;
    rvga_word mem_addr_o;
    rvga_word mem_data_o;
    rvga_word mem_data_i;
    logic     mem_resp_v_i;

    logic     err_timeout_o;

    // Arbiter view.
    modport slave (
        input  imem_r_v_i, imem_addr_i,
        output imem_data_o, imem_resp_v_o,
        input  dmem_r_v_i, dmem_w_v_i, dmem_addr_i, dmem_data_i,
        output dmem_data_o, dmem_resp_v_o,
        output mem_r_v_o, mem_w_v_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_resp_v_i,
        output err_timeout_o
    );

    // Core + memory view.
    modport master (
        output imem_r_v_i, imem_addr_i,
        input  imem_data_o, imem_resp_v_o,
        output dmem_r_v_i, dmem_w_v_i, dmem_addr_i, dmem_data_i,
        input  dmem_data_o, dmem_resp_v_o,
        input  mem_r_v_o, mem_w_v_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_resp_v_i,
        input  err_timeout_o
    );

endinterface

// File: rtl/rvga_mem_arbiter.sv
// Single-port memory arbiter: data priority, imem anti-starvation, stale-response
// filtering and a no-response watchdog.

// Grant selection plus the saturating count of dmem grants taken while imem waits.
module rvga_arb_prio #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic imem_req,
    input  logic dmem_req,
    output logic grant_i_c,
    output logic grant_d_c
);
    localparam int unsigned BW = 4;

    logic [BW-1:0] burst_q;
    logic          force_i;

    // Data wins unless imem has already been passed over MAX_D_BURST times.
    always_comb begin
        force_i   = imem_req && (burst_q == BW'(MAX_D_BURST));
        grant_d_c = arb_en && dmem_req && !force_i;
        grant_i_c = arb_en && imem_req && !grant_d_c;
    end

    // Burst count grows only while imem is kept waiting; any other grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else if (grant_d_c && imem_req) begin
            if (burst_q != BW'(MAX_D_BURST)) begin
                burst_q <= burst_q + BW'(1);
            end
        end else if (grant_d_c || grant_i_c) begin
            burst_q <= '0;
        end
    end
endmodule

module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_BURST    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rvga_mem_arbiter_if.slave  bus
);
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    rvga_arb_state_e state_q;
    rvga_mem_req_t   req_q;
    logic            mem_r_v_q;
    logic            mem_w_v_q;
    rvga_word        imem_data_q;
    rvga_word        dmem_data_q;
    logic            imem_resp_q;
    logic            dmem_resp_q;
    logic            err_q;
    logic [WD_W-1:0] wd_q;

    logic d_req_c;
    logic i_own_c;
    logic d_own_c;
    logic wd_expire_c;
    logic grant_i_c;
    logic grant_d_c;

    // Owner still asking for the same address decides whether a response is live.
    always_comb begin
        d_req_c     = bus.dmem_r_v_i | bus.dmem_w_v_i;
        i_own_c     = bus.imem_r_v_i && (bus.imem_addr_i == req_q.addr);
        d_own_c     = d_req_c && (bus.dmem_addr_i == req_q.addr);
        wd_expire_c = (TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    end

    rvga_arb_prio #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_prio (
        .clk       (clk_i),
        .rst       (rst_i),
        .arb_en    (state_q == IDLE),
        .imem_req  (bus.imem_r_v_i),
        .dmem_req  (d_req_c),
        .grant_i_c (grant_i_c),
        .grant_d_c (grant_d_c)
    );

    // Transaction FSM: latch on grant, hold until response or watchdog abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            mem_r_v_q   <= 1'b0;
            mem_w_v_q   <= 1'b0;
            imem_data_q <= '0;
            dmem_data_q <= '0;
            imem_resp_q <= 1'b0;
            dmem_resp_q <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            imem_resp_q <= 1'b0;
            dmem_resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_d_c) begin
                        state_q   <= DBUSY;
                        req_q     <= '{addr: bus.dmem_addr_i, data: bus.dmem_data_i};
                        mem_r_v_q <= !bus.dmem_w_v_i;
                        mem_w_v_q <= bus.dmem_w_v_i;
                        wd_q      <= '0;
                    end else if (grant_i_c) begin
                        state_q   <= IBUSY;
                        req_q     <= '{addr: bus.imem_addr_i, data: '0};
                        mem_r_v_q <= 1'b1;
                        mem_w_v_q <= 1'b0;
                        wd_q      <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (bus.mem_resp_v_i) begin
                        state_q   <= IDLE;
                        mem_r_v_q <= 1'b0;
                        mem_w_v_q <= 1'b0;
                        if (state_q == IBUSY && i_own_c) begin
                            imem_resp_q <= 1'b1;
                            imem_data_q <= bus.mem_data_i;
                        end
                        if (state_q == DBUSY && d_own_c) begin
                            dmem_resp_q <= 1'b1;
                            dmem_data_q <= bus.mem_data_i;
                        end
                    end else if (wd_expire_c) begin
                        state_q   <= IDLE;
                        mem_r_v_q <= 1'b0;
                        mem_w_v_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output drive from registers only.
    assign bus.mem_r_v_o     = mem_r_v_q;
    assign bus.mem_w_v_o     = mem_w_v_q;
    assign bus.mem_addr_o    = req_q.addr;
    assign bus.mem_data_o    = req_q.data;
    assign bus.imem_data_o   = imem_data_q;
    assign bus.imem_resp_v_o = imem_resp_q;
    assign bus.dmem_data_o   = dmem_data_q;
    assign bus.dmem_resp_v_o = dmem_resp_q;
    assign bus.err_timeout_o = err_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Scoreboard bench for rvga_mem_arbiter: directed requests, a latency-2 memory
// model, and a monitor that checks grants and response pulses against queues.
module tb_rvga_mem_arbiter;

    localparam int MEM_LAT = 2;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } gnt_t;

    logic clk;
    logic rst;

    rvga_mem_arbiter_if bus ();

    rvga_mem_arbiter #(
        .MAX_D_BURST    (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          checks;
    int          failures;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    gnt_t        gq[$];
    logic [31:0] mem[logic [31:0]];
    bit          mute;
    bit          inject;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Memory model: answers MEM_LAT cycles into a strobe unless muted; writes answer with 0.
    initial begin : mem_model
        int lat_cnt;
        lat_cnt = 0;
        forever begin
            @(negedge clk);
            if (inject) begin
                bus.mem_data_i   = 32'hBAD0BAD0;
                bus.mem_resp_v_i = 1'b1;
                inject           = 1'b0;
                lat_cnt          = 0;
            end else if (bus.mem_resp_v_i) begin
                bus.mem_resp_v_i = 1'b0;
                lat_cnt          = 0;
            end else if ((bus.mem_r_v_o || bus.mem_w_v_o) && !mute) begin
                lat_cnt++;
                if (lat_cnt == MEM_LAT) begin
                    if (bus.mem_w_v_o) begin
                        mem[bus.mem_addr_o] = bus.mem_data_o;
                        bus.mem_data_i      = 32'h0;
                    end else begin
                        bus.mem_data_i = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : 32'h0;
                    end
                    bus.mem_resp_v_i = 1'b1;
                    lat_cnt          = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: pops expected grants on each new strobe and expected data on each pulse.
    initial begin : monitor
        bit          prev_busy;
        bit          busy;
        gnt_t        g;
        logic [31:0] e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_resp_v_o === 1'b1) begin
                if (exp_i.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL imem_resp unexpected pulse data=%h required=no pulse", bus.imem_data_o);
                end else begin
                    e = exp_i.pop_front();
                    chk("imem_data", bus.imem_data_o, e);
                end
            end
            if (bus.dmem_resp_v_o === 1'b1) begin
                if (exp_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dmem_resp unexpected pulse data=%h required=no pulse", bus.dmem_data_o);
                end else begin
                    e = exp_d.pop_front();
                    chk("dmem_data", bus.dmem_data_o, e);
                end
            end
            busy = (bus.mem_r_v_o === 1'b1) || (bus.mem_w_v_o === 1'b1);
            if (busy && !prev_busy) begin
                if (gq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL grant unexpected addr=%h required=no grant", bus.mem_addr_o);
                end else begin
                    g = gq.pop_front();
                    chk("grant_addr", bus.mem_addr_o, g.addr);
                    chk("grant_wr", 32'(bus.mem_w_v_o), 32'(g.wr));
                    if (g.wr) chk("grant_wdata", bus.mem_data_o, g.data);
                end
            end
            prev_busy = busy;
        end
    end

    // One request from one port; drops it on the negedge its response pulse is seen.
    task automatic single(input string nm, input bit is_d, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        gq.push_back('{wr: wr, addr: a, data: d});
        if (is_d) exp_d.push_back(exp);
        else      exp_i.push_back(exp);
        @(negedge clk);
        if (is_d) begin
            bus.dmem_r_v_i  = 1'b1;
            bus.dmem_w_v_i  = wr;
            bus.dmem_addr_i = a;
            bus.dmem_data_i = d;
        end else begin
            bus.imem_r_v_i  = 1'b1;
            bus.imem_addr_i = a;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (k < 2) begin
                chk({nm, "_rd_strobe"}, 32'(bus.mem_r_v_o), 32'(!wr));
                chk({nm, "_wr_strobe"}, 32'(bus.mem_w_v_o), 32'(wr));
                chk({nm, "_addr"}, bus.mem_addr_o, a);
                if (wr) chk({nm, "_wdata"}, bus.mem_data_o, d);
            end
            got = ((is_d ? bus.dmem_resp_v_o : bus.imem_resp_v_o) === 1'b1);
        end
        bus.dmem_r_v_i = 1'b0;
        bus.dmem_w_v_i = 1'b0;
        bus.imem_r_v_i = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_resp_wait actual=no pulse in 50 cycles required=pulse", nm);
        end
    endtask

    initial begin : global_bound
        #200000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        int pulses;
        int hi;
        checks   = 0;
        failures = 0;
        mute     = 1'b0;
        inject   = 1'b0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'hA5A50200;
        mem[32'h300] = 32'h33330300;
        rst              = 1'b1;
        bus.imem_r_v_i   = 1'b0;
        bus.imem_addr_i  = 32'h0;
        bus.dmem_r_v_i   = 1'b0;
        bus.dmem_w_v_i   = 1'b0;
        bus.dmem_addr_i  = 32'h0;
        bus.dmem_data_i  = 32'h0;
        bus.mem_data_i   = 32'h0;
        bus.mem_resp_v_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_mem_r_v", 32'(bus.mem_r_v_o), 32'd0);
        chk("rst_mem_w_v", 32'(bus.mem_w_v_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_data", bus.mem_data_o, 32'h0);
        chk("rst_imem_data", bus.imem_data_o, 32'h0);
        chk("rst_dmem_data", bus.dmem_data_o, 32'h0);
        chk("rst_imem_resp", 32'(bus.imem_resp_v_o), 32'd0);
        chk("rst_dmem_resp", 32'(bus.dmem_resp_v_o), 32'd0);
        chk("rst_err", 32'(bus.err_timeout_o), 32'd0);

        // imem-only fetch
        single("fetch100", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);

        // Both ports hammering: D,D,D,D,I,D,D,D,D,I
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
                gq.push_back('{wr: 1'b0, addr: 32'h200, data: 32'h0});
                exp_d.push_back(32'hA5A50200);
            end
            gq.push_back('{wr: 1'b0, addr: 32'h100, data: 32'h0});
            exp_i.push_back(32'hDEADBEEF);
        end
        @(negedge clk);
        bus.imem_r_v_i  = 1'b1;
        bus.imem_addr_i = 32'h100;
        bus.dmem_r_v_i  = 1'b1;
        bus.dmem_addr_i = 32'h200;
        pulses = 0;
        for (int k = 0; k < 300 && pulses < 10; k++) begin
            @(negedge clk);
            if (bus.imem_resp_v_o === 1'b1) pulses++;
            if (bus.dmem_resp_v_o === 1'b1) pulses++;
        end
        bus.imem_r_v_i = 1'b0;
        bus.dmem_r_v_i = 1'b0;
        chk("burst_pulse_count", 32'(pulses), 32'd10);
        chk("burst_grants_left", 32'(gq.size()), 32'd0);

        // Store (read and write both high counts as write), then load it back
        single("store40", 1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0);
        single("load40", 1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678);

        // Fetch redirected mid-flight: first response is stale
        gq.push_back('{wr: 1'b0, addr: 32'h100, data: 32'h0});
        gq.push_back('{wr: 1'b0, addr: 32'h300, data: 32'h0});
        exp_i.push_back(32'h33330300);
        @(negedge clk);
        bus.imem_r_v_i  = 1'b1;
        bus.imem_addr_i = 32'h100;
        @(negedge clk);
        chk("redir_first_addr", bus.mem_addr_o, 32'h100);
        bus.imem_addr_i = 32'h300;
        hi = 0;
        for (int k = 0; k < 50 && hi == 0; k++) begin
            @(negedge clk);
            if (bus.imem_resp_v_o === 1'b1) hi = 1;
        end
        bus.imem_r_v_i = 1'b0;
        chk("redir_pulse_seen", 32'(hi), 32'd1);

        // Memory never answers: abort after 8 busy cycles
        mute = 1'b1;
        gq.push_back('{wr: 1'b0, addr: 32'h200, data: 32'h0});
        @(negedge clk);
        bus.dmem_r_v_i  = 1'b1;
        bus.dmem_addr_i = 32'h200;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.mem_r_v_o === 1'b1) hi++;
            else if (hi > 0) break;
        end
        bus.dmem_r_v_i = 1'b0;
        chk("wd_busy_cycles", 32'(hi), 32'd8);
        chk("wd_err_set", 32'(bus.err_timeout_o), 32'd1);
        mute = 1'b0;
        single("post_wd_fetch", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        chk("wd_err_sticky", 32'(bus.err_timeout_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wd_err_cleared", 32'(bus.err_timeout_o), 32'd0);

        // Reset during DBUSY, then a late memory response while idle
        mute = 1'b1;
        gq.push_back('{wr: 1'b0, addr: 32'h200, data: 32'h0});
        @(negedge clk);
        bus.dmem_r_v_i  = 1'b1;
        bus.dmem_addr_i = 32'h200;
        @(negedge clk);
        chk("rstbusy_strobe_before", 32'(bus.mem_r_v_o), 32'd1);
        rst            = 1'b1;
        bus.dmem_r_v_i = 1'b0;
        @(negedge clk);
        chk("rstbusy_r_strobe", 32'(bus.mem_r_v_o), 32'd0);
        chk("rstbusy_w_strobe", 32'(bus.mem_w_v_o), 32'd0);
        chk("rstbusy_addr", bus.mem_addr_o, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 inject = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("late_imem_resp", 32'(bus.imem_resp_v_o), 32'd0);
            chk("late_dmem_resp", 32'(bus.dmem_resp_v_o), 32'd0);
            chk("late_r_strobe", 32'(bus.mem_r_v_o), 32'd0);
        end
        mute = 1'b0;

        chk("exp_i_left", 32'(exp_i.size()), 32'd0);
        chk("exp_d_left", 32'(exp_d.size()), 32'd0);
        chk("grants_left", 32'(gq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
